// File: rtl/tlb_pkg.sv
// Shared sizing and state encoding for the L2 TLB search sequencer.
package tlb_pkg;

  localparam int TLB_SET_W    = 5;
  localparam int TLB_OFFSET_W = 4;
  localparam int TLB_ADDR_W   = TLB_SET_W + TLB_OFFSET_W + 1;
  localparam int TLB_BANK_BIT = TLB_ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DRAIN,
    DONE
  } l2_search_state_t;

endpackage

// File: rtl/l2_tlb_search_ctrl.sv
// Search sequencer for one check_ram slice of the L2 TLB: scans both banks of a set,
// two entries per cycle, and arbitrates config writes into the same RAM.
module l2_tlb_search_ctrl
  import tlb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int PAGE_SIZE      = 4096,
  parameter int SET_WIDTH      = TLB_SET_W,
  parameter int OFFSET_WIDTH   = TLB_OFFSET_W,
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [ADDR_WIDTH-1:0]             req_addr_i,
  input  logic                              req_rw_i,
  input  logic                              cfg_valid_i,
  output logic                              cfg_ready_o,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]   cfg_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0]         cfg_wdata_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic                              resp_hit_o,
  output logic                              resp_prot_o,
  output logic                              resp_multi_hit_o,
  output logic                              resp_master_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]   resp_hit_addr_o,
  output logic [ADDR_WIDTH-1:0]             cr_in_addr_o,
  output logic                              cr_rw_type_o,
  output logic                              cr_ram_we_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]   cr_port0_addr_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]   cr_port1_addr_o,
  output logic [RAM_DATA_WIDTH-1:0]         cr_ram_wdata_o,
  output logic                              cr_searching_o,
  output logic [OFFSET_WIDTH-1:0]           cr_offset_addr_d_o,
  output logic                              cr_start_search_o,
  output logic                              cr_send_outputs_o,
  input  logic                              cr_hit_i,
  input  logic                              cr_prot_i,
  input  logic                              cr_multi_hit_i,
  input  logic                              cr_master_i,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]   cr_hit_addr_i
);

  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int AW         = SET_WIDTH + OFFSET_WIDTH + 1;
  localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = '1;

  l2_search_state_t          state_q, state_d;
  logic [OFFSET_WIDTH-1:0]   cnt_q, cnt_d;
  logic [OFFSET_WIDTH-1:0]   offset_d_q, offset_d_d;
  logic [SET_WIDTH-1:0]      set_q, set_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      rw_q, rw_d;
  logic                      searching_q, searching_d;
  logic                      hit_q, hit_d;
  logic                      prot_q, prot_d;
  logic                      multi_q, multi_d;
  logic                      master_q, master_d;
  logic [AW-1:0]             hit_addr_q, hit_addr_d;
  logic                      issue;
  logic                      capture;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      offset_d_q  <= '0;
      set_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      searching_q <= 1'b0;
      hit_q       <= 1'b0;
      prot_q      <= 1'b0;
      multi_q     <= 1'b0;
      master_q    <= 1'b0;
      hit_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      offset_d_q  <= offset_d_d;
      set_q       <= set_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      searching_q <= searching_d;
      hit_q       <= hit_d;
      prot_q      <= prot_d;
      multi_q     <= multi_d;
      master_q    <= master_d;
      hit_addr_q  <= hit_addr_d;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks from a discarded search.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    offset_d_d = offset_d_q;
    set_d      = set_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    hit_d      = hit_q;
    prot_d     = prot_q;
    multi_d    = multi_q;
    master_d   = master_q;
    hit_addr_d = hit_addr_q;
    issue      = 1'b0;
    capture    = 1'b0;

    req_ready_o        = 1'b0;
    cfg_ready_o        = 1'b0;
    resp_valid_o       = 1'b0;
    resp_hit_o         = 1'b0;
    resp_prot_o        = 1'b0;
    resp_multi_hit_o   = 1'b0;
    resp_master_o      = 1'b0;
    resp_hit_addr_o    = '0;
    cr_in_addr_o       = '0;
    cr_rw_type_o       = 1'b0;
    cr_ram_we_o        = 1'b0;
    cr_port0_addr_o    = '0;
    cr_port1_addr_o    = '0;
    cr_ram_wdata_o     = '0;
    cr_searching_o     = 1'b0;
    cr_offset_addr_d_o = '0;
    cr_start_search_o  = 1'b0;
    cr_send_outputs_o  = 1'b0;

    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            cfg_ready_o     = 1'b1;
            cr_ram_we_o     = 1'b1;
            cr_port0_addr_o = cfg_addr_i;
            cr_ram_wdata_o  = cfg_wdata_i;
          end else begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
              addr_d  = req_addr_i;
              rw_d    = req_rw_i;
              set_d   = req_addr_i[IGNORE_LSB +: SET_WIDTH];
              cnt_d   = '0;
              state_d = SEARCH;
            end
          end
        end
        SEARCH: begin
          cr_start_search_o = !searching_q;
          // A hit on returning data stops the scan even if the last offset was just issued.
          if (searching_q && cr_hit_i) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            issue = 1'b1;
            if (cnt_q == LAST_OFFSET) begin
              state_d = DRAIN;
            end else begin
              cnt_d = cnt_q + OFFSET_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          capture = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          resp_valid_o      = 1'b1;
          resp_hit_o        = hit_q;
          resp_prot_o       = prot_q;
          resp_multi_hit_o  = multi_q;
          resp_master_o     = master_q;
          resp_hit_addr_o   = hit_addr_q;
          cr_send_outputs_o = resp_ready_i;
          if (resp_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (issue) begin
        cr_port0_addr_o = {1'b0, set_q, cnt_q};
        cr_port1_addr_o = {1'b1, set_q, cnt_q};
        offset_d_d      = cnt_q;
      end

      if (capture) begin
        hit_d      = cr_hit_i;
        prot_d     = cr_hit_i & cr_prot_i;
        multi_d    = cr_hit_i & cr_multi_hit_i;
        master_d   = cr_hit_i & cr_master_i;
        hit_addr_d = cr_hit_i ? cr_hit_addr_i : '0;
      end

      cr_in_addr_o       = addr_q;
      cr_rw_type_o       = rw_q;
      cr_searching_o     = searching_q;
      cr_offset_addr_d_o = offset_d_q;
    end

    searching_d = issue;
  end

endmodule

// File: tb/tb_l2_tlb_search_ctrl.sv
// Scoreboard bench for l2_tlb_search_ctrl with a small two-bank check_ram model.
module tb_l2_tlb_search_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_rw_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [9:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_hit_o;
  logic        resp_prot_o;
  logic        resp_multi_hit_o;
  logic        resp_master_o;
  logic [9:0]  resp_hit_addr_o;
  logic [31:0] cr_in_addr_o;
  logic        cr_rw_type_o;
  logic        cr_ram_we_o;
  logic [9:0]  cr_port0_addr_o;
  logic [9:0]  cr_port1_addr_o;
  logic [31:0] cr_ram_wdata_o;
  logic        cr_searching_o;
  logic [3:0]  cr_offset_addr_d_o;
  logic        cr_start_search_o;
  logic        cr_send_outputs_o;
  logic        cr_hit_i;
  logic        cr_prot_i;
  logic        cr_multi_hit_i;
  logic        cr_master_i;
  logic [9:0]  cr_hit_addr_i;

  typedef struct {
    logic       hit;
    logic       prot;
    logic       multi;
    logic       master;
    logic [9:0] haddr;
    int         lat;
    int         reads;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   stall_req = 0;
  int   starts = 0;
  int   sends = 0;

  l2_tlb_search_ctrl dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_rw_i           (req_rw_i),
    .cfg_valid_i        (cfg_valid_i),
    .cfg_ready_o        (cfg_ready_o),
    .cfg_addr_i         (cfg_addr_i),
    .cfg_wdata_i        (cfg_wdata_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_hit_o         (resp_hit_o),
    .resp_prot_o        (resp_prot_o),
    .resp_multi_hit_o   (resp_multi_hit_o),
    .resp_master_o      (resp_master_o),
    .resp_hit_addr_o    (resp_hit_addr_o),
    .cr_in_addr_o       (cr_in_addr_o),
    .cr_rw_type_o       (cr_rw_type_o),
    .cr_ram_we_o        (cr_ram_we_o),
    .cr_port0_addr_o    (cr_port0_addr_o),
    .cr_port1_addr_o    (cr_port1_addr_o),
    .cr_ram_wdata_o     (cr_ram_wdata_o),
    .cr_searching_o     (cr_searching_o),
    .cr_offset_addr_d_o (cr_offset_addr_d_o),
    .cr_start_search_o  (cr_start_search_o),
    .cr_send_outputs_o  (cr_send_outputs_o),
    .cr_hit_i           (cr_hit_i),
    .cr_prot_i          (cr_prot_i),
    .cr_multi_hit_i     (cr_multi_hit_i),
    .cr_master_i        (cr_master_i),
    .cr_hit_addr_i      (cr_hit_addr_i)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // check_ram model: entry = {valid, write_perm, master, 9'b0, vpn[19:0]}, 1-cycle read latency
  logic [31:0] mem [1024];
  logic [31:0] rd0, rd1;
  logic        h0, h1;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rd0 = '0;
    rd1 = '0;
  end

  always @(posedge clk_i) begin
    if (cr_ram_we_o) mem[cr_port0_addr_o] <= cr_ram_wdata_o;
    rd0 <= mem[cr_port0_addr_o];
    rd1 <= mem[cr_port1_addr_o];
  end

  function automatic logic entryMatch(input logic [31:0] e, input logic [31:0] va);
    return e[31] && (e[19:0] == va[31:12]);
  endfunction

  function automatic logic [31:0] mkEntry(input logic wperm, input logic master, input logic [19:0] vpn);
    return {1'b1, wperm, master, 9'b0, vpn};
  endfunction

  assign h0             = cr_searching_o && entryMatch(rd0, cr_in_addr_o);
  assign h1             = cr_searching_o && entryMatch(rd1, cr_in_addr_o);
  assign cr_hit_i       = h0 | h1;
  assign cr_multi_hit_i = h0 & h1;
  assign cr_prot_i      = h0 ? (cr_rw_type_o & ~rd0[30]) : (h1 & cr_rw_type_o & ~rd1[30]);
  assign cr_master_i    = h0 ? rd0[29] : (h1 & rd1[29]);
  assign cr_hit_addr_i  = {~h0, cr_in_addr_o[16:12], cr_offset_addr_d_o};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response-ready driver: holds ready low for stall_req valid cycles of each response
  initial begin
    int stall_cnt = 0;
    resp_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) stall_cnt++;
      else stall_cnt = 0;
      resp_ready_i = (stall_cnt >= stall_req);
    end
  end

  // Monitor: compares every presented response against the scoreboard head
  initial begin
    int   rd_idx = 0;
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        seen = 0;
      end else begin
        if (cr_start_search_o) begin
          starts++;
          rd_idx = 0;
        end
        if (cr_searching_o) begin
          checkOutput("read_offset", {28'b0, cr_offset_addr_d_o}, rd_idx);
          rd_idx++;
        end
        if (cr_send_outputs_o) sends++;
        if (resp_valid_o) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_resp_valid", {31'b0, resp_valid_o}, 0);
          end else begin
            e = sb[0];
            if (!seen) begin
              checkOutput("resp_latency", cyc - accept_cyc, e.lat);
              checkOutput("read_count", rd_idx, e.reads);
              seen = 1;
            end
            checkOutput("resp_hit", {31'b0, resp_hit_o}, {31'b0, e.hit});
            checkOutput("resp_prot", {31'b0, resp_prot_o}, {31'b0, e.prot});
            checkOutput("resp_multi_hit", {31'b0, resp_multi_hit_o}, {31'b0, e.multi});
            checkOutput("resp_master", {31'b0, resp_master_o}, {31'b0, e.master});
            checkOutput("resp_hit_addr", {22'b0, resp_hit_addr_o}, {22'b0, e.haddr});
            checkOutput("searching_in_done", {31'b0, cr_searching_o}, 0);
            if (resp_ready_i) begin
              checkOutput("send_outputs", {31'b0, cr_send_outputs_o}, 1);
              void'(sb.pop_front());
              seen = 0;
            end
          end
        end else begin
          seen = 0;
        end
      end
    end
  end

  task automatic cfgWrite(input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk_i);
    cfg_valid_i = 1'b1;
    cfg_addr_i  = a;
    cfg_wdata_i = d;
    #1;
    while (!cfg_ready_o && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checkOutput("cfg_ready", {31'b0, cfg_ready_o}, 1);
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
  endtask

  // Issues one lookup; the expected response is queued when one is due
  task automatic applyStimulus(input logic [31:0] addr, input logic rw, input bit expect_resp,
                               input exp_t e);
    int n = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_rw_i    = rw;
    #1;
    while (!req_ready_o && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checkOutput("req_ready", {31'b0, req_ready_o}, 1);
    accept_cyc = cyc;
    if (expect_resp) sb.push_back(e);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic waitResponses();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("resp_timeout_pending", sb.size(), 0);
    sb.delete();
    @(negedge clk_i);
  endtask

  initial begin
    exp_t e;
    int   n;

    rst_i        = 1'b1;
    req_valid_i  = 1'b1;
    req_addr_i   = 32'h1234_5000;
    req_rw_i     = 1'b0;
    cfg_valid_i  = 1'b1;
    cfg_addr_i   = 10'h053;
    cfg_wdata_i  = 32'hFFFF_FFFF;

    // Outputs must stay quiet under reset even with both requesters active
    repeat (3) @(negedge clk_i);
    checkOutput("rst_req_ready", {31'b0, req_ready_o}, 0);
    checkOutput("rst_cfg_ready", {31'b0, cfg_ready_o}, 0);
    checkOutput("rst_ram_we", {31'b0, cr_ram_we_o}, 0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid_o}, 0);
    checkOutput("rst_port0", {22'b0, cr_port0_addr_o}, 0);
    cfg_valid_i = 1'b0;
    req_valid_i = 1'b0;
    rst_i       = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_req_ready", {31'b0, req_ready_o}, 1);

    cfgWrite(10'h053, mkEntry(1'b1, 1'b0, 20'h12345));
    cfgWrite(10'h077, mkEntry(1'b1, 1'b1, 20'h00A27));
    cfgWrite(10'h277, mkEntry(1'b1, 1'b0, 20'h00A27));

    // Hit in bank 0, set 5, offset 3
    e = '{hit: 1'b1, prot: 1'b0, multi: 1'b0, master: 1'b0, haddr: 10'h053, lat: 6, reads: 4};
    applyStimulus(32'h1234_5000, 1'b0, 1'b1, e);
    waitResponses();

    // Full miss scans all 16 offsets
    e = '{hit: 1'b0, prot: 1'b0, multi: 1'b0, master: 1'b0, haddr: 10'h000, lat: 18, reads: 16};
    applyStimulus(32'h0ABC_D000, 1'b0, 1'b1, e);
    waitResponses();

    // Same VPN in both banks at offset 7
    e = '{hit: 1'b1, prot: 1'b0, multi: 1'b1, master: 1'b1, haddr: 10'h077, lat: 10, reads: 8};
    applyStimulus(32'h00A2_7000, 1'b0, 1'b1, e);
    waitResponses();

    // Config and request together: config wins this cycle
    @(negedge clk_i);
    cfg_valid_i = 1'b1;
    cfg_addr_i  = 10'h112;
    cfg_wdata_i = mkEntry(1'b0, 1'b1, 20'h55551);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h5555_1000;
    req_rw_i    = 1'b1;
    #1;
    checkOutput("arb_cfg_ready", {31'b0, cfg_ready_o}, 1);
    checkOutput("arb_req_ready", {31'b0, req_ready_o}, 0);
    checkOutput("arb_ram_we", {31'b0, cr_ram_we_o}, 1);
    checkOutput("arb_port0", {22'b0, cr_port0_addr_o}, 32'h112);
    checkOutput("arb_wdata", cr_ram_wdata_o, 32'hA005_5551);
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("arb_req_ready_next", {31'b0, req_ready_o}, 1);
    accept_cyc = cyc;
    e = '{hit: 1'b1, prot: 1'b1, multi: 1'b0, master: 1'b1, haddr: 10'h112, lat: 5, reads: 3};
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    stall_req   = 6;
    // Config raised mid-search is held off until the response has been consumed
    cfg_valid_i = 1'b1;
    cfg_addr_i  = 10'h3F0;
    cfg_wdata_i = 32'h0;
    n = 0;
    @(negedge clk_i);
    while (!cfg_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("cfg_stall_cycles", cyc - accept_cyc, 11);
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
    stall_req   = 0;
    waitResponses();

    // Reset during the fourth search cycle discards the lookup
    e = '{hit: 1'b0, prot: 1'b0, multi: 1'b0, master: 1'b0, haddr: 10'h000, lat: 0, reads: 0};
    applyStimulus(32'h0ABC_D000, 1'b0, 1'b0, e);
    n = 0;
    while (cyc != accept_cyc + 4 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_rst_resp_valid", {31'b0, resp_valid_o}, 0);
    checkOutput("post_rst_searching", {31'b0, cr_searching_o}, 0);
    checkOutput("post_rst_in_addr", cr_in_addr_o, 0);
    checkOutput("post_rst_port1", {22'b0, cr_port1_addr_o}, 0);
    checkOutput("post_rst_send", {31'b0, cr_send_outputs_o}, 0);
    checkOutput("post_rst_req_ready", {31'b0, req_ready_o}, 1);
    repeat (20) @(negedge clk_i);

    // Fresh lookup after reset behaves normally
    e = '{hit: 1'b1, prot: 1'b0, multi: 1'b0, master: 1'b0, haddr: 10'h053, lat: 6, reads: 4};
    applyStimulus(32'h1234_5000, 1'b0, 1'b1, e);
    waitResponses();

    checkOutput("send_pulse_count", sends, 5);
    checkOutput("start_pulse_count", starts, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
